mem_arbiter4: RTL

MEM_ARBITER4 -- requirements
Module: mem_arbiter4

---
 rtl/mem_arbiter4.sv | 99 +++++++++
 1 files changed

// File: rtl/mem_arbiter4.sv
// Four-requester round-robin arbiter for a single shared memory port.
// One transaction at a time; ends on mem_ack or after TIMEOUT busy cycles.
module mem_arbiter4 #(
    parameter logic [15:0] TIMEOUT = 16'd1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       mem_valid,
    input  logic       mem_ack,
    output logic [3:0] done,
    output logic [3:0] err
);

    localparam logic [15:0] LP_CNT_LAST = TIMEOUT - 16'd1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t      r_state;
    logic [3:0]  r_grant;
    logic [1:0]  r_sel;
    logic        r_mem_valid;
    logic [1:0]  r_last;
    logic [15:0] r_cnt;

    logic        w_busy;
    logic        w_ack_hit;
    logic        w_to_hit;
    logic [1:0]  w_win;
    logic [1:0]  w_idx;
    logic        w_found;

    assign w_busy    = (r_state == ST_BUSY);
    assign w_ack_hit = w_busy & mem_ack;
    assign w_to_hit  = w_busy & ~mem_ack & (r_cnt == LP_CNT_LAST);

    assign grant     = r_grant;
    assign sel       = r_sel;
    assign mem_valid = r_mem_valid;
    assign done      = w_ack_hit ? r_grant : 4'b0000;
    assign err       = w_to_hit  ? r_grant : 4'b0000;

    // Round-robin search starting just after the last served requester
    always_comb begin
        w_win   = 2'd0;
        w_found = 1'b0;
        w_idx   = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            w_idx = r_last + 2'(k);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_grant     <= 4'b0000;
            r_sel       <= 2'd0;
            r_mem_valid <= 1'b0;
            r_last      <= 2'd3;
            r_cnt       <= 16'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|req) begin
                        r_state     <= ST_BUSY;
                        r_grant     <= 4'b0001 << w_win;
                        r_sel       <= w_win;
                        r_mem_valid <= 1'b1;
                        r_cnt       <= 16'd0;
                    end else begin
                        r_grant     <= 4'b0000;
                        r_mem_valid <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    // ack and timeout share the same exit path
                    if (w_ack_hit || w_to_hit) begin
                        r_state     <= ST_IDLE;
                        r_last      <= r_sel;
                        r_grant     <= 4'b0000;
                        r_mem_valid <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
            endcase
        end
    end

endmodule
